// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential minifloat multiplier.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MUL,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, N cycles after start.
module mant_mul_seq #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  // NOTE: every register here is a few flops, so all of them take the async
  // reset; sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{N{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

  // done marks the cycle performing the final step; prod is complete after it.
  assign done = busy_q && (cnt_q == CW'(N - 1));
  assign busy = busy_q;
  assign prod = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// Multicycle minifloat multiplier with valid/ready handshakes, truncate/RNE
// rounding, overflow saturation and underflow flush.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W  = 3,
  parameter  int FRAC_W = 4,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic         unf
);

  localparam int M       = FRAC_W + 1;
  localparam int P       = 2 * M;
  localparam int EW      = EXP_W + 2;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic          rnd_q;
  logic          sign_q, zero_q;
  logic [EW-1:0] exp_q;
  logic [P-1:0]  mant_q;

  logic          mul_start, mul_busy, mul_done;
  logic [P-1:0]  prod;

  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] frac_t, frac_r;
  logic [FRAC_W:0]   frac_sum;
  logic              guard, sticky, inc;
  logic [EW-1:0]     exp_r;
  logic [W-1:0]      res_d;
  logic              ovf_d, unf_d;

  assign ea = a_q[W-2 -: EXP_W];
  assign eb = b_q[W-2 -: EXP_W];

  mant_mul_seq #(.N(M)) u_mant_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     ({1'b1, a_q[FRAC_W-1:0]}),
    .b     ({1'b1, b_q[FRAC_W-1:0]}),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = UNPACK;
      UNPACK:  state_d = MUL;
      MUL:     if (mul_done) state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !mul_busy;
    out_valid = (state_q == DONE);
    mul_start = (state_q == UNPACK);
  end

  // Rounding and classification of the normalised mantissa (leading 1 at MSB).
  always_comb begin
    frac_t   = mant_q[P-2 -: FRAC_W];
    guard    = mant_q[P-2-FRAC_W];
    sticky   = |mant_q[P-3-FRAC_W:0];
    inc      = (rnd_q == RND_RNE) && guard && (sticky || frac_t[0]);
    frac_sum = {1'b0, frac_t} + M'(inc);
    frac_r   = frac_sum[FRAC_W-1:0];
    exp_r    = exp_q + EW'(frac_sum[FRAC_W]);
    res_d    = {sign_q, exp_r[EXP_W-1:0], frac_r};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (zero_q) begin
      res_d = {sign_q, {(W-1){1'b0}}};
    end else if ($signed(exp_r) > EXP_MAX) begin
      res_d = {sign_q, {(W-1){1'b1}}};
      ovf_d = 1'b1;
    end else if ($signed(exp_r) < 1) begin
      res_d = {sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      rnd_q  <= RND_TRUNC;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      res    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= op1;
          b_q   <= op2;
          rnd_q <= rnd_mode;
        end
        UNPACK: begin
          sign_q <= a_q[W-1] ^ b_q[W-1];
          exp_q  <= EW'(ea) + EW'(eb) - BIAS;
          zero_q <= (ea == '0) || (eb == '0);
        end
        // Product of two [1,2) mantissas lies in [1,4): at most one shift.
        NORM: begin
          if (prod[P-1]) begin
            mant_q <= prod;
            exp_q  <= exp_q + EW'(1);
          end else begin
            mant_q <= prod << 1;
          end
        end
        ROUND: begin
          res <= res_d;
          ovf <= ovf_d;
          unf <= unf_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed vectors, handshake and reset
// sequences, and random operands against a real-arithmetic reference model.
module tb_fp_mul_seq;

  localparam int EXP_W = 3;
  localparam int FRAC_W = 4;
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int LAT = FRAC_W + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         rnd_mode = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         in_ready, out_valid, ovf, unf;
  logic [W-1:0] res;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .unf       (unf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rm;
    logic [W-1:0] r;
    logic         o;
    logic         u;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exact product of the two decoded values, renormalised into [1,2) and
  // rounded by comparing the discarded remainder against one half.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic rm,
                                output logic [W-1:0] r, output logic o, output logic u);
    int  ea, eb, fa, fb, e, t, be;
    real x, scaled, rem;
    logic sgn;
    sgn = a[W-1] ^ b[W-1];
    ea = int'(a[W-2 -: EXP_W]);
    eb = int'(b[W-2 -: EXP_W]);
    fa = int'(a[FRAC_W-1:0]);
    fb = int'(b[FRAC_W-1:0]);
    o = 1'b0;
    u = 1'b0;
    r = {sgn, {(W-1){1'b0}}};
    if (ea == 0 || eb == 0) return;
    x = real'(((1 << FRAC_W) + fa) * ((1 << FRAC_W) + fb));
    e = (ea - BIAS) + (eb - BIAS) - 2 * FRAC_W;
    while (x >= 2.0) begin
      x = x / 2.0;
      e++;
    end
    scaled = x * real'(1 << FRAC_W);
    t = int'($floor(scaled));
    rem = scaled - real'(t);
    if (rm && (rem > 0.5 || (rem == 0.5 && (t % 2) == 1))) t++;
    if (t == (2 << FRAC_W)) begin
      t = 1 << FRAC_W;
      e++;
    end
    be = e + BIAS;
    if (be > EMAX) begin
      o = 1'b1;
      r = {sgn, {(W-1){1'b1}}};
    end else if (be < 1) begin
      u = 1'b1;
    end else begin
      r = {sgn, EXP_W'(be), FRAC_W'(t - (1 << FRAC_W))};
    end
  endfunction

  // Called at a negedge; returns at the negedge after DONE is left (out_ready=1).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic rm,
                        output logic [W-1:0] r, output logic o, output logic u, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    op1 = a;
    op2 = b;
    rnd_mode = rm;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op1 = W'($urandom);
    op2 = W'($urandom);
    rnd_mode = 1'($urandom_range(1, 0));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    r = res;
    o = ovf;
    u = unf;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic [W-1:0] r, er, held;
    logic o, u, eo, eu, seen;
    int lat, n;

    vecs[0]  = '{a: 8'h38, b: 8'h38, rm: 1'b0, r: 8'h42, o: 1'b0, u: 1'b0};
    vecs[1]  = '{a: 8'hC0, b: 8'h48, rm: 1'b0, r: 8'hD8, o: 1'b0, u: 1'b0};
    vecs[2]  = '{a: 8'h33, b: 8'h33, rm: 1'b0, r: 8'h36, o: 1'b0, u: 1'b0};
    vecs[3]  = '{a: 8'h33, b: 8'h33, rm: 1'b1, r: 8'h37, o: 1'b0, u: 1'b0};
    vecs[4]  = '{a: 8'h37, b: 8'h36, rm: 1'b1, r: 8'h40, o: 1'b0, u: 1'b0};
    vecs[5]  = '{a: 8'h37, b: 8'h36, rm: 1'b0, r: 8'h3F, o: 1'b0, u: 1'b0};
    vecs[6]  = '{a: 8'h7F, b: 8'h7F, rm: 1'b0, r: 8'h7F, o: 1'b1, u: 1'b0};
    vecs[7]  = '{a: 8'h7F, b: 8'h7F, rm: 1'b1, r: 8'h7F, o: 1'b1, u: 1'b0};
    vecs[8]  = '{a: 8'h10, b: 8'h10, rm: 1'b0, r: 8'h00, o: 1'b0, u: 1'b1};
    vecs[9]  = '{a: 8'h90, b: 8'h10, rm: 1'b0, r: 8'h80, o: 1'b0, u: 1'b1};
    vecs[10] = '{a: 8'h00, b: 8'hB8, rm: 1'b0, r: 8'h80, o: 1'b0, u: 1'b0};
    vecs[11] = '{a: 8'h00, b: 8'hB8, rm: 1'b1, r: 8'h80, o: 1'b0, u: 1'b0};

    #12;
    check("reset_res", 32'(res), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_unf", 32'(unf), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].rm, r, o, u, lat);
      check($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].o));
      check($sformatf("vec%0d_unf", i), 32'(u), 32'(vecs[i].u));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
    end

    // Back-pressure: hold DONE for 5 cycles while offering a second operand.
    out_ready = 1'b0;
    op1 = 8'hC0;
    op2 = 8'h48;
    rnd_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'h1);
    held = res;
    check("bp_first_res", 32'(held), 32'hD8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op1 = 8'h38;
      op2 = 8'h38;
      @(negedge clk);
      check($sformatf("bp_hold_res%0d", i), 32'(res), 32'hD8);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 32'(out_valid), 32'h0);
    check("bp_ready_back", 32'(in_ready), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("bp_no_queued_op", 32'(seen), 32'h0);

    // Asynchronous reset in the middle of MUL.
    run_op(8'h7F, 8'h7F, 1'b0, r, o, u, lat);
    check("pre_reset_ovf", 32'(o), 32'h1);
    op1 = 8'h38;
    op2 = 8'h38;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mul_in_ready_low", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_res", 32'(res), 32'h0);
    check("async_rst_ovf", 32'(ovf), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h33, 8'h33, 1'b1, r, o, u, lat);
    check("post_reset_res", 32'(r), 32'h37);
    check("post_reset_latency", 32'(lat), 32'(LAT));

    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a, b;
      logic rm;
      a = W'($urandom);
      b = W'($urandom);
      rm = 1'($urandom_range(1, 0));
      model(a, b, rm, er, eo, eu);
      run_op(a, b, rm, r, o, u, lat);
      check($sformatf("rand_res %h*%h rm=%0d", a, b, rm), 32'(r), 32'(er));
      check($sformatf("rand_ovf %h*%h", a, b), 32'(o), 32'(eo));
      check($sformatf("rand_unf %h*%h", a, b), 32'(u), 32'(eu));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Parametrised, multicycle minifloat multiplier; next generation of the team's 8-bit (1/3/4) float multiplier.
- Adds:
  - configurable exponent and fraction widths
  - valid/ready handshakes on both sides
  - selectable truncate or round-to-nearest-even
  - overflow saturation and underflow flush, each with a flag
  - asynchronous reset
- Sits in the arithmetic datapath between operand registers and the result bus.

Parameters:
- EXP_W, 3, exponent field width; bias = 2^(EXP_W-1)-1.
- FRAC_W, 4, stored fraction width; hidden leading 1.
- W, 1+EXP_W+FRAC_W, total word width, derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- op1  in  W  operand A {sign, exp, frac}.
- op2  in  W  operand B.
- rnd_mode  in  1  0 = truncate (legacy), 1 = RNE; sampled at accept.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- res  out  W  product.
- ovf  out  1  result saturated; valid with out_valid.
- unf  out  1  result flushed to zero; valid with out_valid.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state returns to IDLE
  - res=0, ovf=0, unf=0, out_valid=0, in_ready=1
  - internal registers cleared
- Number format:
  - exp field 0 means zero, whatever the fraction; no denormals, inf or NaN
  - an all-ones exp field is an ordinary finite value
- Accept: in_valid & in_ready on a rising edge. op1, op2 and rnd_mode are latched; later input changes are ignored.
- States and transitions:
  - IDLE: in_ready=1. Accept -> UNPACK.
  - UNPACK (1 cycle):
    - mantissas {1,frac}, each FRAC_W+1 bits
    - sign = s1^s2
    - signed exponent sum e = e1+e2-bias, held in EXP_W+2 bits
    - zero flag set if either exp field is 0
  - MUL (FRAC_W+1 cycles): shift-add, one multiplier bit per cycle; 2*FRAC_W+2-bit product. A cycle counter ends the state.
  - NORM (1 cycle): if product MSB is 1, shift right by 1 and e+1. At most one shift, since the product lies in [1,4).
  - ROUND (1 cycle):
    - guard bit = first dropped bit; sticky = OR of the remaining dropped bits
    - RNE increments when guard & (sticky | lsb)
    - a mantissa carry-out sets frac=0 and e+1
    - then classify, in this priority:
      1. zero flag -> {sign,0,0}, no flags
      2. e > 2^EXP_W-1 -> {sign, all ones, all ones}, ovf=1
      3. e < 1 -> {sign,0,0}, unf=1
      4. otherwise pack normally
    - res, ovf, unf are registered and enter DONE.
  - DONE:
    - out_valid=1; res, ovf, unf held stable
    - out_ready -> IDLE, out_valid drops next cycle
    - with out_ready tied high, DONE lasts 1 cycle
- Latency: accept edge to out_valid = FRAC_W+4 cycles (8 at default). Zero operands take the same fixed latency.
- Throughput: one operation at a time. in_ready=0 outside IDLE.
- Back-pressure: out_ready low holds DONE indefinitely with no change to res.
- Input handshake: in_valid outside IDLE is ignored; no queuing.

Decomposition:
- Package fp_mul_pkg holds:
  - state enum: IDLE, UNPACK, MUL, NORM, ROUND, DONE
  - RND_TRUNC / RND_RNE constants
  - bias function of EXP_W
- Sub-module mant_mul_seq: sequential shift-add mantissa multiplier with start/busy/done. Parametrised by FRAC_W+1.
- Top level owns the FSM, exponent path, rounding and packing.

Test Plan:
All values use the default parameters.
1. 0x38 × 0x38 (1.5×1.5), rnd_mode=0 -> res=0x42, ovf=0, unf=0; out_valid 8 cycles after accept.
2. 0xC0 × 0x48 (-2×3) -> res=0xD8 (-6), no flags.
3. Rounding:
   - 0x33 × 0x33: rnd_mode=0 -> 0x36; rnd_mode=1 -> 0x37.
   - 0x37 × 0x36: rnd_mode=1 -> 0x40 (carry into exponent); rnd_mode=0 -> 0x3F.
4. Overflow, underflow and zero:
   - 0x7F × 0x7F -> 0x7F, ovf=1.
   - 0x10 × 0x10 -> 0x00, unf=1.
   - 0x90 × 0x10 -> 0x80, unf=1.
   - 0x00 × 0xB8 -> 0x80, no flags.
5. Handshake:
   - out_ready low for 5 cycles in DONE -> res held, in_ready=0, a second in_valid ignored.
   - After out_ready: next accept no earlier than 1 cycle later.
6. Reset mid-operation: rst_n low during MUL for any duration -> outputs zero immediately (asynchronous), in_ready=1. The next operation completes correctly.
